// File: rtl/servo_pkg.sv
// Shared types and constants for the servo capture datapath.
package servo_pkg;

  localparam int unsigned CNT_W      = 32;
  localparam int unsigned MIN_PERIOD = 2;

  typedef enum logic {
    ST_IDLE,
    ST_MEAS
  } meter_state_t;

  // Saturating increment; counters must never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input, plus a delayed copy
// for rising-edge detection in the clk_in domain.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = sync_q[SYNC_STAGES-1] & ~s_d_q;

endmodule

// File: rtl/pwm_period_meter.sv
// Measures period and high time of each full cycle of sig_in in clk_in cycles,
// flagging a timeout when no rising edge arrives within TIMEOUT cycles.
module pwm_period_meter
  import servo_pkg::*;
#(
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT     = 32'd50_000_000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT < MIN_PERIOD) begin : g_bad_param
    $error("pwm_period_meter: illegal SYNC_STAGES or TIMEOUT");
  end

  logic s;
  logic rise;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_in(clk_in),
    .rst   (rst),
    .sig_in(sig_in),
    .s     (s),
    .rise  (rise)
  );

  meter_state_t     state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  // Loading 1 on rise makes pcnt == N at the next rise N cycles later.
  always_comb begin
    pcnt_d = rise ? CNT_W'(1) : sat_inc(pcnt_q);
    hcnt_d = hcnt_q;
    if (rise) begin
      hcnt_d = CNT_W'(1);
    end else if (s) begin
      hcnt_d = sat_inc(hcnt_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d   = ST_MEAS;
          timeout_d = 1'b0;
        end
      end
      ST_MEAS: begin
        // A rise coinciding with pcnt == TIMEOUT is still a valid measurement.
        if (rise) begin
          period_d  = pcnt_q;
          high_d    = hcnt_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
        end else if (pcnt_q == TIMEOUT) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_period_meter.sv
// Scoreboard bench for pwm_period_meter: stimulus pushes expected measurements,
// monitors pop and compare on each meas_valid strobe.
`timescale 1ns / 100ps
module tb_pwm_period_meter;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TO   = 100;

  typedef struct {
    longint p;
    longint h;
    longint tol;
  } exp_t;

  logic        clk, rst, sig, sig2;
  logic [31:0] period, high_time, period2, high_time2;
  logic        meas_valid, timeout, meas_valid2, timeout2;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  longint last_rise_cyc = 0;
  longint to_rise_cyc = 0;
  exp_t   q[$];
  exp_t   q2[$];
  bit     have_prev = 0;
  longint prev_p = 0, prev_h = 0, last_p = 0, last_h = 0;

  pwm_period_meter #(
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (32'd100)
  ) u_dut (
    .clk_in    (clk),
    .rst       (rst),
    .sig_in    (sig),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .timeout   (timeout)
  );

  pwm_period_meter #(
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (32'd2000)
  ) u_dut_slow (
    .clk_in    (clk),
    .rst       (rst),
    .sig_in    (sig2),
    .period    (period2),
    .high_time (high_time2),
    .meas_valid(meas_valid2),
    .timeout   (timeout2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input longint act, input longint exp,
                       input longint tol = 0);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  // Monitor for the fast instance; also tracks when timeout rises.
  initial begin
    bit   to_prev = 0;
    bit   mv_prev = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (timeout && !to_prev) to_rise_cyc = cyc;
        if (meas_valid) begin
          if (mv_prev) check("strobe_one_cycle", 1, 0);
          if (q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
          end else begin
            e = q.pop_front();
            check("period", longint'(period), e.p, e.tol);
            check("high_time", longint'(high_time), e.h, e.tol);
            check("timeout_on_strobe", longint'(timeout), 0);
          end
        end
      end
      to_prev = timeout;
      mv_prev = meas_valid;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && meas_valid2) begin
        if (q2.size() == 0) begin
          check("unexpected_strobe_slow", 1, 0);
        end else begin
          e = q2.pop_front();
          check("period_async", longint'(period2), e.p, e.tol);
          check("high_time_async", longint'(high_time2), e.h, e.tol);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d expected finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Each rise completes the previous full period, if one was in progress.
  task automatic gen_wave(input int h, input int l, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      sig = 1'b1;
      last_rise_cyc = cyc;
      if (have_prev) begin
        e = '{p: prev_p, h: prev_h, tol: 0};
        q.push_back(e);
        last_p = prev_p;
        last_h = prev_h;
      end
      prev_p = h + l;
      prev_h = h;
      have_prev = 1;
      tick(h);
      sig = 1'b0;
      tick(l);
    end
  endtask

  // Rise seen SYNC cycles after the drive, pcnt hits TIMEOUT 100 later, one more to register.
  task automatic stop_low(input int n);
    sig = 1'b0;
    to_rise_cyc = 0;
    tick(n);
    check("timeout_set", longint'(timeout), 1);
    check("timeout_delay", to_rise_cyc - last_rise_cyc, TO + SYNC + 1);
    check("period_held", longint'(period), last_p);
    check("high_time_held", longint'(high_time), last_h);
    check("queue_drained", q.size(), 0);
    have_prev = 0;
  endtask

  initial begin
    exp_t e;
    bit   have_prev2 = 0;
    rst  = 1'b1;
    sig  = 1'b0;
    sig2 = 1'b0;
    tick(3);
    check("rst_period", longint'(period), 0);
    check("rst_high_time", longint'(high_time), 0);
    check("rst_meas_valid", longint'(meas_valid), 0);
    check("rst_timeout", longint'(timeout), 0);
    rst = 1'b0;
    tick(5);

    gen_wave(5, 5, 6);
    gen_wave(3, 17, 3);
    gen_wave(12, 8, 3);
    stop_low(120);

    // Restart: arming rise clears timeout without a strobe.
    gen_wave(5, 5, 1);
    check("timeout_cleared_by_arm", longint'(timeout), 0);
    check("no_strobe_on_arm", q.size(), 0);
    gen_wave(5, 5, 4);

    gen_wave(1, 1, 6);
    gen_wave(50, 50, 3);
    check("no_timeout_at_period_eq_timeout", longint'(timeout), 0);
    stop_low(120);

    // Reset four cycles into a period discards the partial measurement.
    gen_wave(5, 5, 3);
    gen_wave(4, 0, 1);
    rst = 1'b1;
    sig = 1'b0;
    tick(1);
    check("midrst_period", longint'(period), 0);
    check("midrst_high_time", longint'(high_time), 0);
    check("midrst_meas_valid", longint'(meas_valid), 0);
    check("midrst_timeout", longint'(timeout), 0);
    rst = 1'b0;
    have_prev = 0;
    tick(5);
    gen_wave(5, 5, 3);
    check("queue_after_midrst", q.size(), 0);

    // Stuck high from reset release: one arming rise, then timeout.
    rst = 1'b1;
    sig = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(120);
    check("stuck_high_timeout", longint'(timeout), 1);
    check("stuck_high_period", longint'(period), 0);
    check("stuck_high_high_time", longint'(high_time), 0);
    sig = 1'b0;
    tick(5);

    // Asynchronous phase on the slow instance: 1000-cycle period, 300 high.
    #(real'($urandom_range(1, 99)) / 10.0);
    for (int i = 0; i < 5; i++) begin
      sig2 = 1'b1;
      if (have_prev2) begin
        e = '{p: 1000, h: 300, tol: 1};
        q2.push_back(e);
      end
      have_prev2 = 1;
      #3000;
      sig2 = 1'b0;
      #7000;
    end
    tick(10);
    check("queue_drained_async", q2.size(), 0);
    check("queue_drained_final", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
